// File: rtl/e203_brslv_pkg.sv
// Shared types and constants for the registered branch-resolve stage.
//   flush_kind_e : cause of a pending flush (BJP/FENCEI/MRET/DRET)
//   brslv_state_e: resolve FSM state (IDLE/PEND)
//   INC_RVC/INC_RV32: sequential PC increment for 16/32-bit instructions
package e203_brslv_pkg;

    typedef enum logic [1:0] {
        KIND_BJP    = 2'd0,
        KIND_FENCEI = 2'd1,
        KIND_MRET   = 2'd2,
        KIND_DRET   = 2'd3
    } flush_kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } brslv_state_e;

    localparam int unsigned INC_RVC  = 2;
    localparam int unsigned INC_RV32 = 4;

endpackage

// File: rtl/e203_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count up by one (held at all-ones once reached)
//   clr      : synchronous clear, wins over inc
//   cnt      : current count
module e203_sat_cnt
    import e203_brslv_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/e203_exu_brslv_reg.sv
// Registered branch-resolve stage at the EXU commit point.
// Inputs : committed instruction (valid/rv32/class bits/prediction/pc/imm),
//          mepc/dpc, pending non-ALU flush, IFU flush ack, perf_clr.
// Outputs: cmt_i_ready, registered flush request/target/kind, one-cycle
//          mret/dret/fencei enables on the flush handshake, and saturating
//          BJP / mispredict performance counters.
// rst_n is a synchronous ACTIVE-HIGH reset despite its name.
module e203_exu_brslv_reg
    import e203_brslv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RVC_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmt_i_valid,
    output logic             cmt_i_ready,
    input  logic             cmt_i_rv32,
    input  logic             cmt_i_bjp,
    input  logic             cmt_i_fencei,
    input  logic             cmt_i_mret,
    input  logic             cmt_i_dret,
    input  logic             cmt_i_bjp_prdt,
    input  logic             cmt_i_bjp_rslv,
    input  logic [XLEN-1:0]  cmt_i_pc,
    input  logic [XLEN-1:0]  cmt_i_imm,
    input  logic [XLEN-1:0]  csr_epc_r,
    input  logic [XLEN-1:0]  csr_dpc_r,
    input  logic             nonalu_excpirq_flush_req_raw,
    output logic             brchmis_flush_req,
    input  logic             brchmis_flush_ack,
    output logic [XLEN-1:0]  brchmis_flush_pc,
    output logic [1:0]       brchmis_flush_kind,
    output logic             cmt_mret_ena,
    output logic             cmt_dret_ena,
    output logic             cmt_fencei_ena,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_bjp_cnt,
    output logic [CNT_W-1:0] perf_mis_cnt
);

    brslv_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    flush_kind_e     kind_q, kind_d;

    logic            is_br, bjp_mis, need_flush, accept;
    flush_kind_e     kind_sel;
    logic [XLEN-1:0] inc, add_b, sum, tgt;

    assign is_br      = cmt_i_bjp | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
    assign bjp_mis    = cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);
    assign need_flush = bjp_mis | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
    assign accept     = cmt_i_valid & cmt_i_ready;

    always_comb begin
        kind_sel = KIND_BJP;
        if (cmt_i_dret) begin
            kind_sel = KIND_DRET;
        end else if (cmt_i_mret) begin
            kind_sel = KIND_MRET;
        end else if (cmt_i_fencei) begin
            kind_sel = KIND_FENCEI;
        end
    end

    // Single adder: pc+imm only for a not-predicted-but-taken BJP, otherwise
    // pc+inc (fence.i and predicted-taken-but-not-taken BJP).
    assign inc   = ((RVC_EN != 0) && !cmt_i_rv32) ? XLEN'(INC_RVC) : XLEN'(INC_RV32);
    assign add_b = ((kind_sel == KIND_BJP) && !cmt_i_bjp_prdt && cmt_i_bjp_rslv)
                   ? cmt_i_imm : inc;
    assign sum   = cmt_i_pc + add_b;
    assign tgt   = (kind_sel == KIND_DRET) ? csr_dpc_r :
                   (kind_sel == KIND_MRET) ? csr_epc_r : sum;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        kind_d         = kind_q;
        cmt_i_ready    = 1'b0;
        cmt_mret_ena   = 1'b0;
        cmt_dret_ena   = 1'b0;
        cmt_fencei_ena = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A pending non-ALU flush blocks branch-class commits only.
                cmt_i_ready = ~is_br | ~nonalu_excpirq_flush_req_raw;
                if (cmt_i_valid && cmt_i_ready && need_flush) begin
                    state_d = ST_PEND;
                    pc_d    = tgt;
                    kind_d  = kind_sel;
                end
            end
            ST_PEND: begin
                if (brchmis_flush_ack) begin
                    state_d        = ST_IDLE;
                    cmt_mret_ena   = (kind_q == KIND_MRET);
                    cmt_dret_ena   = (kind_q == KIND_DRET);
                    cmt_fencei_ena = (kind_q == KIND_FENCEI);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            kind_q  <= KIND_BJP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kind_q  <= kind_d;
        end
    end

    assign brchmis_flush_req  = (state_q == ST_PEND);
    assign brchmis_flush_pc   = pc_q;
    assign brchmis_flush_kind = kind_q;

    e203_sat_cnt #(.W(CNT_W)) u_bjp_cnt (
        .clk (clk),
        .rst (rst_n),
        .inc (accept & cmt_i_bjp),
        .clr (perf_clr),
        .cnt (perf_bjp_cnt)
    );

    e203_sat_cnt #(.W(CNT_W)) u_mis_cnt (
        .clk (clk),
        .rst (rst_n),
        .inc (accept & bjp_mis),
        .clr (perf_clr),
        .cnt (perf_mis_cnt)
    );

endmodule

// File: tb/tb_e203_exu_brslv_reg.sv
// Bench for e203_exu_brslv_reg: two instances (RVC on / 16-bit counters and
// RVC off / 2-bit counters) share one stimulus stream; a behavioural model
// predicts every output each cycle, plus directed literal expectations.
module tb_e203_exu_brslv_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, rv32, bjp, fencei, mret, dret, prdt, rslv;
    logic [31:0] pc, imm, epc, dpc;
    logic        nonalu, ack, clr;

    logic        rdy1, req1, mena1, dena1, fena1;
    logic [31:0] fpc1;
    logic [1:0]  kind1;
    logic [15:0] bcnt1, mcnt1;
    logic        rdy2, req2, mena2, dena2, fena2;
    logic [31:0] fpc2;
    logic [1:0]  kind2;
    logic [1:0]  bcnt2, mcnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    e203_exu_brslv_reg #(.XLEN(32), .RVC_EN(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst), .cmt_i_valid(valid), .cmt_i_ready(rdy1),
        .cmt_i_rv32(rv32), .cmt_i_bjp(bjp), .cmt_i_fencei(fencei),
        .cmt_i_mret(mret), .cmt_i_dret(dret), .cmt_i_bjp_prdt(prdt),
        .cmt_i_bjp_rslv(rslv), .cmt_i_pc(pc), .cmt_i_imm(imm),
        .csr_epc_r(epc), .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu),
        .brchmis_flush_req(req1), .brchmis_flush_ack(ack),
        .brchmis_flush_pc(fpc1), .brchmis_flush_kind(kind1),
        .cmt_mret_ena(mena1), .cmt_dret_ena(dena1), .cmt_fencei_ena(fena1),
        .perf_clr(clr), .perf_bjp_cnt(bcnt1), .perf_mis_cnt(mcnt1)
    );

    e203_exu_brslv_reg #(.XLEN(32), .RVC_EN(0), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst), .cmt_i_valid(valid), .cmt_i_ready(rdy2),
        .cmt_i_rv32(rv32), .cmt_i_bjp(bjp), .cmt_i_fencei(fencei),
        .cmt_i_mret(mret), .cmt_i_dret(dret), .cmt_i_bjp_prdt(prdt),
        .cmt_i_bjp_rslv(rslv), .cmt_i_pc(pc), .cmt_i_imm(imm),
        .csr_epc_r(epc), .csr_dpc_r(dpc), .nonalu_excpirq_flush_req_raw(nonalu),
        .brchmis_flush_req(req2), .brchmis_flush_ack(ack),
        .brchmis_flush_pc(fpc2), .brchmis_flush_kind(kind2),
        .cmt_mret_ena(mena2), .cmt_dret_ena(dena2), .cmt_fencei_ena(fena2),
        .perf_clr(clr), .perf_bjp_cnt(bcnt2), .perf_mis_cnt(mcnt2)
    );

    // ---------------- behavioural model ----------------
    bit          m_valid = 0;
    bit          m_pend;
    logic [31:0] m_pc [2];
    int unsigned m_kind;
    int unsigned m_bjp [2];
    int unsigned m_mis [2];
    int unsigned m_max [2] = '{65535, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] target(input bit rvc);
        logic [31:0] step;
        step = (rvc && !rv32) ? 32'd2 : 32'd4;
        if (dret)           return dpc;
        if (mret)           return epc;
        if (fencei)         return pc + step;
        if (prdt && !rslv)  return pc + step;
        return pc + imm;
    endfunction

    // Compare all outputs against the model, then advance the model across
    // the coming rising edge using the currently applied inputs.
    task automatic cycle_check();
        bit isbr, nf, rdy, acc, mis;
        isbr = bjp | fencei | mret | dret;
        mis  = bjp & (prdt ^ rslv);
        nf   = mis | fencei | mret | dret;
        rdy  = !m_pend && (!isbr || !nonalu);
        if (m_valid) begin
            chk("ready1", 64'(rdy1), 64'(rdy));
            chk("ready2", 64'(rdy2), 64'(rdy));
            chk("req1", 64'(req1), 64'(m_pend));
            chk("req2", 64'(req2), 64'(m_pend));
            chk("pc1", 64'(fpc1), 64'(m_pc[0]));
            chk("pc2", 64'(fpc2), 64'(m_pc[1]));
            chk("kind1", 64'(kind1), 64'(m_kind));
            chk("kind2", 64'(kind2), 64'(m_kind));
            chk("mret_ena", 64'(mena1), 64'(m_pend && ack && m_kind == 2));
            chk("dret_ena", 64'(dena1), 64'(m_pend && ack && m_kind == 3));
            chk("fencei_ena", 64'(fena1), 64'(m_pend && ack && m_kind == 1));
            chk("bjp_cnt1", 64'(bcnt1), 64'(m_bjp[0]));
            chk("mis_cnt1", 64'(mcnt1), 64'(m_mis[0]));
            chk("bjp_cnt2", 64'(bcnt2), 64'(m_bjp[1]));
            chk("mis_cnt2", 64'(mcnt2), 64'(m_mis[1]));
        end
        if (rst) begin
            m_valid = 1;
            m_pend  = 0;
            m_pc    = '{32'h0, 32'h0};
            m_kind  = 0;
            m_bjp   = '{0, 0};
            m_mis   = '{0, 0};
        end else if (m_valid) begin
            acc = valid && rdy;
            if (m_pend) begin
                if (ack) m_pend = 0;
            end else if (acc && nf) begin
                m_pend  = 1;
                m_kind  = dret ? 3 : mret ? 2 : fencei ? 1 : 0;
                m_pc[0] = target(1'b1);
                m_pc[1] = target(1'b0);
            end
            for (int i = 0; i < 2; i++) begin
                if (clr) begin
                    m_bjp[i] = 0;
                    m_mis[i] = 0;
                end else begin
                    if (acc && bjp && m_bjp[i] < m_max[i]) m_bjp[i]++;
                    if (acc && mis && m_mis[i] < m_max[i]) m_mis[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid = 0; bjp = 0; fencei = 0; mret = 0; dret = 0;
        prdt = 0; rslv = 0; rv32 = 1; nonalu = 0; ack = 0; clr = 0;
    endtask

    task automatic set_cmd(input bit b, input bit f, input bit m, input bit d,
                           input bit p, input bit r, input logic [31:0] a,
                           input logic [31:0] i);
        valid = 1; bjp = b; fencei = f; mret = m; dret = d;
        prdt = p; rslv = r; pc = a; imm = i;
    endtask

    initial begin
        idle_in();
        pc = '0; imm = '0; epc = '0; dpc = '0;
        rst = 1;
        @(posedge clk); #1;
        step();
        rst = 0;

        // reset values
        chk("rst_req", 64'(req1), 64'd0);
        chk("rst_pc", 64'(fpc1), 64'd0);
        chk("rst_cnt", 64'(bcnt1), 64'd0);

        // mispredicted not-taken BJP
        set_cmd(1, 0, 0, 0, 0, 1, 32'h1000, 32'h40);
        #1 chk("t1_ready", 64'(rdy1), 64'd1);
        step();
        idle_in();
        valid = 1;
        #1;
        chk("t1_req", 64'(req1), 64'd1);
        chk("t1_pc", 64'(fpc1), 64'h1040);
        chk("t1_kind", 64'(kind1), 64'd0);
        chk("t1_pend_ready", 64'(rdy1), 64'd0);
        step(); step();
        chk("t1_hold_req", 64'(req1), 64'd1);
        ack = 1;
        #1 chk("t1_ack_ready", 64'(rdy1), 64'd0);
        step();
        ack = 0; valid = 0;
        #1;
        chk("t1_req_drop", 64'(req1), 64'd0);
        chk("t1_mis", 64'(mcnt1), 64'd1);
        chk("t1_bjp", 64'(bcnt1), 64'd1);

        // predicted-taken, not taken, 16-bit instruction
        set_cmd(1, 0, 0, 0, 1, 0, 32'h2002, 32'h0);
        rv32 = 0;
        step();
        idle_in();
        chk("t2_pc_rvc", 64'(fpc1), 64'h2004);
        chk("t2_pc_norvc", 64'(fpc2), 64'h2006);
        ack = 1; step(); ack = 0;

        // mret
        epc = 32'h8000_0100;
        set_cmd(0, 0, 1, 0, 0, 0, 32'h300, 32'h0);
        step();
        idle_in();
        chk("t3_pc", 64'(fpc1), 64'h8000_0100);
        chk("t3_kind", 64'(kind1), 64'd2);
        chk("t3_mret_idle", 64'(mena1), 64'd0);
        ack = 1;
        #1 chk("t3_mret_ena", 64'(mena1), 64'd1);
        step();
        ack = 0;
        #1 chk("t3_mret_done", 64'(mena1), 64'd0);

        // dret
        dpc = 32'h800;
        set_cmd(0, 0, 0, 1, 0, 0, 32'h400, 32'h0);
        step();
        idle_in();
        chk("t4_pc", 64'(fpc1), 64'h800);
        chk("t4_kind", 64'(kind1), 64'd3);
        ack = 1;
        #1 chk("t4_dret_ena", 64'(dena1), 64'd1);
        step();
        ack = 0;

        // non-ALU flush blocks a fence.i in IDLE
        set_cmd(0, 1, 0, 0, 0, 0, 32'h500, 32'h0);
        nonalu = 1;
        #1 chk("t5_ready", 64'(rdy1), 64'd0);
        step();
        chk("t5_noflush", 64'(req1), 64'd0);

        // fence.i wraps, then a non-ALU request cannot disturb it
        nonalu = 0;
        set_cmd(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
        step();
        chk("t6_wrap", 64'(fpc1), 64'h0);
        chk("t6_kind", 64'(kind1), 64'd1);
        nonalu = 1;
        set_cmd(0, 1, 0, 0, 0, 0, 32'h1234, 32'h0);
        step();
        chk("t6_hold_req", 64'(req1), 64'd1);
        chk("t6_hold_pc", 64'(fpc1), 64'h0);
        idle_in();
        ack = 1;
        #1 chk("t6_fencei_ena", 64'(fena1), 64'd1);
        step(); ack = 0;

        // saturation on the 2-bit instance
        clr = 1; step(); clr = 0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1, 0, 0, 0, 1, 1, 32'h600, 32'h8);
            step();
        end
        idle_in();
        chk("t7_bjp16", 64'(bcnt1), 64'd5);
        chk("t7_bjp2", 64'(bcnt2), 64'd3);
        chk("t7_mis2", 64'(mcnt2), 64'd0);
        chk("t7_noflush", 64'(req1), 64'd0);

        // clear beats increment
        set_cmd(1, 0, 0, 0, 0, 1, 32'h700, 32'h8);
        clr = 1;
        step();
        idle_in();
        chk("t8_clr_bjp", 64'(bcnt1), 64'd0);
        chk("t8_clr_mis", 64'(mcnt2), 64'd0);
        chk("t8_flush", 64'(req1), 64'd1);

        // reset while pending
        rst = 1; step(); rst = 0;
        chk("t9_req", 64'(req1), 64'd0);
        chk("t9_cnt", 64'(bcnt1), 64'd0);
        valid = 1;
        #1 chk("t9_ready", 64'(rdy1), 64'd1);
        step();

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            idle_in();
            r      = $urandom_range(0, 9);
            valid  = ($urandom_range(0, 3) != 0);
            rv32   = $urandom_range(0, 1) == 1;
            prdt   = $urandom_range(0, 1) == 1;
            rslv   = $urandom_range(0, 1) == 1;
            pc     = $urandom;
            imm    = $urandom;
            epc    = $urandom;
            dpc    = $urandom;
            bjp    = (r <= 3) || (r == 7 && $urandom_range(0, 1) == 1);
            fencei = (r == 4) || (r == 7 && $urandom_range(0, 1) == 1);
            mret   = (r == 5) || (r == 7 && $urandom_range(0, 1) == 1);
            dret   = (r == 6) || (r == 7 && $urandom_range(0, 1) == 1);
            nonalu = ($urandom_range(0, 3) == 0);
            ack    = ($urandom_range(0, 2) == 0);
            clr    = ($urandom_range(0, 31) == 0);
            rst    = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;
        idle_in();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
